// File: rtl/a2d_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : a2d_arbiter
// Purpose  : Round-robin arbiter sharing one A2D SPI converter between three
//            requesters. A grant starts one conversion, waits for the result
//            (or a timeout), returns it through res_out with a one-cycle rdy
//            pulse to the granted requester, then rearbitrates.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            req[2:0]            - per-requester request (held until rdy)
//            req_chnnl[8:0]      - channel select, 3 bits per requester
//            cnv_cmplt, res[11:0]- conversion-done pulse and its result
//            strt_cnv, chnnl[2:0]- start pulse and channel to the SPI block
//            gnt[2:0], rdy[2:0]  - one-hot grant and result-ready pulse
//            res_out[11:0]       - registered result (shared)
//            busy, tmo_err       - not-idle flag, sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module a2d_arbiter #(
    parameter logic [15:0] TMO_CYCLES = 16'd2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [8:0]  req_chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [2:0]  gnt,
    output logic [2:0]  rdy,
    output logic [11:0] res_out,
    output logic        busy,
    output logic        tmo_err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_winner;
    logic [1:0]  r_last;
    logic [15:0] r_cnt;

    logic [1:0]  w_cand1;
    logic [1:0]  w_cand2;
    logic [1:0]  w_winner;
    logic [2:0]  w_sel_ch;
    logic        w_tmo_hit;

    // Round-robin search order: last+1, last+2, last (all mod 3).
    always_comb begin
        w_cand1  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_cand2  = (w_cand1 == 2'd2) ? 2'd0 : w_cand1 + 2'd1;
        w_winner = r_last;
        if (req[w_cand1]) begin
            w_winner = w_cand1;
        end else if (req[w_cand2]) begin
            w_winner = w_cand2;
        end
    end

    always_comb begin
        w_sel_ch = req_chnnl[2:0];
        case (w_winner)
            2'd1:    w_sel_ch = req_chnnl[5:3];
            2'd2:    w_sel_ch = req_chnnl[8:6];
            default: w_sel_ch = req_chnnl[2:0];
        endcase
    end

    assign w_tmo_hit = (r_cnt == (TMO_CYCLES - 16'd1));

    // All outputs are registered; chnnl doubles as the latched channel so
    // later changes on req_chnnl cannot disturb a conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_winner <= 2'd0;
            r_last   <= 2'd2;
            r_cnt    <= 16'd0;
            strt_cnv <= 1'b0;
            chnnl    <= 3'b000;
            gnt      <= 3'b000;
            rdy      <= 3'b000;
            res_out  <= 12'h000;
            busy     <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req != 3'b000) begin
                        r_winner <= w_winner;
                        chnnl    <= w_sel_ch;
                        gnt      <= 3'b001 << w_winner;
                        strt_cnv <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= c_START;
                    end
                end
                c_START: begin
                    strt_cnv <= 1'b0;
                    r_cnt    <= 16'd0;
                    r_state  <= c_WAIT;
                end
                c_WAIT: begin
                    // A completion on the terminal-count cycle takes priority
                    // over the timeout, leaving tmo_err untouched.
                    if (cnv_cmplt) begin
                        res_out <= res;
                        rdy     <= gnt;
                        gnt     <= 3'b000;
                        chnnl   <= 3'b000;
                        r_state <= c_DONE;
                    end else if (w_tmo_hit) begin
                        res_out <= 12'hFFF;
                        tmo_err <= 1'b1;
                        rdy     <= gnt;
                        gnt     <= 3'b000;
                        chnnl   <= 3'b000;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_DONE: begin
                    rdy     <= 3'b000;
                    r_last  <= r_winner;
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    strt_cnv <= 1'b0;
                    chnnl    <= 3'b000;
                    gnt      <= 3'b000;
                    rdy      <= 3'b000;
                    busy     <= 1'b0;
                    r_state  <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_a2d_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_a2d_arbiter
// Purpose  : Directed self-checking bench for a2d_arbiter with a small
//            expected-result queue filled at stimulus time and drained when
//            rdy pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a2d_arbiter;

    localparam logic [15:0] c_TMO = 16'd20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [8:0]  req_chnnl = 9'd0;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = 12'd0;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [2:0]  gnt;
    logic [2:0]  rdy;
    logic [11:0] res_out;
    logic        busy;
    logic        tmo_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0]  rdy;
        logic [11:0] res;
        logic        tmo;
    } exp_t;

    exp_t sb[$];

    a2d_arbiter #(.TMO_CYCLES(c_TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_chnnl (req_chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .gnt       (gnt),
        .rdy       (rdy),
        .res_out   (res_out),
        .busy      (busy),
        .tmo_err   (tmo_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_strt"},  {31'd0, strt_cnv}, 32'd0);
        chk({tag, "_chnnl"}, {29'd0, chnnl},    32'd0);
        chk({tag, "_gnt"},   {29'd0, gnt},      32'd0);
        chk({tag, "_rdy"},   {29'd0, rdy},      32'd0);
        chk({tag, "_res"},   {20'd0, res_out},  32'd0);
        chk({tag, "_busy"},  {31'd0, busy},     32'd0);
        chk({tag, "_tmo"},   {31'd0, tmo_err},  32'd0);
    endtask

    // Wait for the start pulse, check grant/channel, then step into WAIT.
    task automatic serve_start(input string tag, input int idx, input logic [2:0] ch);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (strt_cnv === 1'b1) found = 1'b1;
        end
        chk({tag, "_strt_seen"}, {31'd0, found}, 32'd1);
        chk({tag, "_gnt"},   {29'd0, gnt},   32'(3'b001 << idx));
        chk({tag, "_chnnl"}, {29'd0, chnnl}, {29'd0, ch});
        chk({tag, "_busy"},  {31'd0, busy},  32'd1);
        @(negedge clk);
        chk({tag, "_strt_1cyc"}, {31'd0, strt_cnv}, 32'd0);
        chk({tag, "_gnt_wait"},  {29'd0, gnt},      32'(3'b001 << idx));
    endtask

    task automatic push_exp(input logic [2:0] r, input logic [11:0] v, input logic t);
        exp_t e;
        e.rdy = r;
        e.res = v;
        e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic pulse_cmplt(input logic [11:0] v);
        cnv_cmplt = 1'b1;
        res       = v;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        res       = 12'($urandom);
    endtask

    // Wait (bounded) for rdy, compare against the queue head, then confirm the
    // pulse is single-cycle and the block is back in IDLE.
    task automatic wait_rdy(input string tag, input bit drop, output int cyc);
        exp_t e;
        cyc = 0;
        while (rdy === 3'b000 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_rdy_seen"}, {31'd0, (rdy !== 3'b000)}, 32'd1);
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        chk({tag, "_rdy"},     {29'd0, rdy},     {29'd0, e.rdy});
        chk({tag, "_res_out"}, {20'd0, res_out}, {20'd0, e.res});
        chk({tag, "_tmo_err"}, {31'd0, tmo_err}, {31'd0, e.tmo});
        if (drop) req = req & ~e.rdy;
        @(negedge clk);
        chk({tag, "_rdy_1cyc"}, {29'd0, rdy},  32'd0);
        chk({tag, "_idle"},     {31'd0, busy}, 32'd0);
        chk({tag, "_res_hold"}, {20'd0, res_out}, {20'd0, e.res});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [2:0] rr_ch [3];
        rr_ch[0] = 3'd1;
        rr_ch[1] = 3'd3;
        rr_ch[2] = 3'd6;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Single request, requester 0, channel 5
        req = 3'b001;
        req_chnnl = 9'b000_000_101;
        serve_start("single", 0, 3'b101);
        push_exp(3'b001, 12'hA5C, 1'b0);
        pulse_cmplt(12'hA5C);
        wait_rdy("single", 1'b1, cyc);

        // Completion on the timeout terminal-count cycle: result wins
        req = 3'b100;
        req_chnnl = 9'b111_000_000;
        serve_start("collide", 2, 3'b111);
        repeat (int'(c_TMO) - 1) @(negedge clk);
        push_exp(3'b100, 12'h123, 1'b0);
        pulse_cmplt(12'h123);
        wait_rdy("collide", 1'b1, cyc);

        // Round-robin from reset with all three requesting
        rst = 1'b1;
        req = 3'b111;
        req_chnnl = {rr_ch[2], rr_ch[1], rr_ch[0]};
        repeat (2) @(negedge clk);
        chk_reset_vals("reset2");
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            serve_start($sformatf("rr%0d", k), k % 3, rr_ch[k % 3]);
            push_exp(3'(3'b001 << (k % 3)), 12'(12'h100 + k), 1'b0);
            pulse_cmplt(12'(12'h100 + k));
            wait_rdy($sformatf("rr%0d", k), 1'b0, cyc);
        end
        req = 3'b000;

        // Timeout on requester 1, with exact WAIT-state length
        req = 3'b010;
        req_chnnl = 9'b000_011_000;
        serve_start("tmo", 1, 3'b011);
        push_exp(3'b010, 12'hFFF, 1'b1);
        wait_rdy("tmo", 1'b1, cyc);
        chk("tmo_latency", cyc, 32'(c_TMO));

        // Later normal conversion keeps the sticky flag
        req = 3'b100;
        req_chnnl = 9'b110_000_000;
        serve_start("after_tmo", 2, 3'b110);
        push_exp(3'b100, 12'h3C3, 1'b1);
        pulse_cmplt(12'h3C3);
        wait_rdy("after_tmo", 1'b1, cyc);

        // Inputs change mid-conversion
        req = 3'b001;
        req_chnnl = 9'b000_000_010;
        serve_start("chg", 0, 3'b010);
        req = 3'b000;
        req_chnnl = 9'h1FF;
        repeat (3) begin
            @(negedge clk);
            chk("chg_chnnl_held", {29'd0, chnnl}, 32'd2);
            chk("chg_gnt_held",   {29'd0, gnt},   32'd1);
        end
        push_exp(3'b001, 12'h5A5, 1'b1);
        pulse_cmplt(12'h5A5);
        wait_rdy("chg", 1'b0, cyc);
        chk("chg_chnnl_idle", {29'd0, chnnl}, 32'd0);

        // Reset during WAIT, then a late completion
        req = 3'b010;
        req_chnnl = 9'b000_100_000;
        serve_start("rstw", 1, 3'b100);
        #1 rst = 1'b1;
        #1 chk_reset_vals("rstw_async");
        @(negedge clk);
        rst = 1'b0;
        req = 3'b000;
        @(negedge clk);
        cnv_cmplt = 1'b1;
        res = 12'hBEE;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_reset_vals("rstw_late");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
